ins_mem_resp: RTL and testbench

INS_MEM_RESP -- requirements
Module: ins_mem_resp

---
 rtl/ins_mem_resp.sv | 106 ++++++++++
 tb/tb_ins_mem_resp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_resp.sv
// Instruction memory with fixed-latency fetch response and program-load port.
// Ports: clock/reset, fetch req/addr, response data/valid/busy/error, write port.
module ins_mem_resp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  ins_mem_resp_clock_in,
  input  logic                  ins_mem_resp_reset_in,
  input  logic                  ins_mem_resp_req_in,
  input  logic [31:0]           ins_mem_resp_addr_in,
  output logic [DATA_WIDTH-1:0] ins_mem_resp_data_out,
  output logic                  ins_mem_resp_valid_out,
  output logic                  ins_mem_resp_busy_out,
  output logic                  ins_mem_resp_error_out,
  input  logic                  ins_mem_resp_wr_en_in,
  input  logic [ADDR_WIDTH-1:0] ins_mem_resp_wr_addr_in,
  input  logic [DATA_WIDTH-1:0] ins_mem_resp_wr_data_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  accept;
  logic [31:0]           rd_addr;
  logic [31:0]           hi_bits;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  fault;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (ins_mem_resp_req_in) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_M1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the array is read on the accepting
  // edge itself, so the live address must feed the read.
  assign rd_addr = accept ? ins_mem_resp_addr_in : addr_q;
  assign hi_bits = rd_addr >> (ADDR_WIDTH + 2);
  assign idx     = rd_addr[ADDR_WIDTH+1:2];
  assign fault   = (|rd_addr[1:0]) | (|hi_bits);

  always_ff @(posedge ins_mem_resp_clock_in) begin
    if (!ins_mem_resp_reset_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) addr_q <= ins_mem_resp_addr_in;
      if (state_d == S_RESP) begin
        err_q  <= fault;
        data_q <= fault ? '0 : mem[idx];
      end
    end
  end

  // Array is never reset; writes are held off during reset.
  always_ff @(posedge ins_mem_resp_clock_in) begin
    if (ins_mem_resp_reset_in && ins_mem_resp_wr_en_in)
      mem[ins_mem_resp_wr_addr_in] <= ins_mem_resp_wr_data_in;
  end

  assign ins_mem_resp_valid_out = (state_q == S_RESP);
  assign ins_mem_resp_busy_out  = (state_q != S_IDLE);
  assign ins_mem_resp_data_out  =
    ins_mem_resp_valid_out ? data_q : '0;
  assign ins_mem_resp_error_out =
    ins_mem_resp_valid_out & err_q;

endmodule

// File: tb/tb_ins_mem_resp.sv
// Directed self-checking bench for ins_mem_resp.
// Covers a 2-wait-state build and a 0-wait-state build on one clock.
module tb_ins_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        req0 = 1'b0;
  logic [31:0] addr0 = 32'd0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [31:0] wr_data = 32'd0;

  logic [31:0] data, data_z;
  logic        valid, busy, err;
  logic        valid_z, busy_z, err_z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ins_mem_resp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(2)) dut (
    .ins_mem_resp_clock_in  (clk),
    .ins_mem_resp_reset_in  (rst),
    .ins_mem_resp_req_in    (req),
    .ins_mem_resp_addr_in   (addr),
    .ins_mem_resp_data_out  (data),
    .ins_mem_resp_valid_out (valid),
    .ins_mem_resp_busy_out  (busy),
    .ins_mem_resp_error_out (err),
    .ins_mem_resp_wr_en_in  (wr_en),
    .ins_mem_resp_wr_addr_in(wr_addr),
    .ins_mem_resp_wr_data_in(wr_data)
  );

  ins_mem_resp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .ins_mem_resp_clock_in  (clk),
    .ins_mem_resp_reset_in  (rst),
    .ins_mem_resp_req_in    (req0),
    .ins_mem_resp_addr_in   (addr0),
    .ins_mem_resp_data_out  (data_z),
    .ins_mem_resp_valid_out (valid_z),
    .ins_mem_resp_busy_out  (busy_z),
    .ins_mem_resp_error_out (err_z),
    .ins_mem_resp_wr_en_in  (wr_en),
    .ins_mem_resp_wr_addr_in(wr_addr),
    .ins_mem_resp_wr_data_in(wr_data)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(); step();
    checks += 4;
    if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    if (data !== 32'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", data); end
    checks += 2;
    if (valid_z !== 1'b0) begin failures++; $display("FAIL rst_valid0 got=%b exp=0", valid_z); end
    if (busy_z !== 1'b0) begin failures++; $display("FAIL rst_busy0 got=%b exp=0", busy_z); end
  endtask

  task automatic load_program;
    rst = 1'b1;
    write_word(8'd0, 32'h0000_0013);
    write_word(8'd1, 32'h0010_0093);
    write_word(8'd3, 32'h0050_0093);
    write_word(8'd5, 32'h1111_1111);
    write_word(8'd7, 32'hAAAA_0007);
  endtask

  // Reset, then request on the very first released edge.
  task automatic test_basic_fetch;
    logic        eb, ev;
    logic [31:0] ed;
    rst = 1'b0;
    step();
    rst = 1'b1; req = 1'b1; addr = 32'h0000_000C;
    step();
    req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      eb = (c <= 3);
      ev = (c == 3);
      ed = ev ? 32'h0050_0093 : 32'd0;
      checks += 4;
      if (busy !== eb) begin failures++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (valid !== ev) begin failures++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, valid, ev); end
      if (data !== ed) begin failures++; $display("FAIL basic_data c=%0d got=%h exp=%h", c, data, ed); end
      if (err !== 1'b0) begin failures++; $display("FAIL basic_err c=%0d got=%b exp=0", c, err); end
      step();
    end
  endtask

  task automatic test_back_to_back;
    logic        eb, ev;
    logic [31:0] ed;
    req = 1'b1; addr = 32'h0000_0000;
    step();
    addr = 32'h0000_0004;
    for (int c = 1; c <= 7; c++) begin
      eb = (c <= 6);
      ev = (c == 3) || (c == 6);
      ed = (c == 3) ? 32'h0000_0013 : (c == 6) ? 32'h0010_0093 : 32'd0;
      checks += 3;
      if (busy !== eb) begin failures++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (valid !== ev) begin failures++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, valid, ev); end
      if (data !== ed) begin failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, data, ed); end
      if (c == 4) req = 1'b0;
      step();
    end
  endtask

  task automatic test_faults;
    logic [31:0] fa [3];
    fa[0] = 32'h0000_0002;
    fa[1] = 32'h0000_0400;
    fa[2] = 32'h8000_000C;
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; addr = fa[i];
      step();
      req = 1'b0;
      step(); step();
      checks += 3;
      if (valid !== 1'b1) begin failures++; $display("FAIL fault_valid a=%h got=%b exp=1", fa[i], valid); end
      if (err !== 1'b1) begin failures++; $display("FAIL fault_err a=%h got=%b exp=1", fa[i], err); end
      if (data !== 32'd0) begin failures++; $display("FAIL fault_data a=%h got=%h exp=0", fa[i], data); end
      step();
    end
  endtask

  task automatic test_collision;
    req = 1'b1; addr = 32'h0000_0014;
    step();
    req = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0;
    checks += 2;
    if (valid !== 1'b1) begin failures++; $display("FAIL coll_valid got=%b exp=1", valid); end
    if (data !== 32'h1111_1111) begin failures++; $display("FAIL coll_old got=%h exp=11111111", data); end
    step();
    req = 1'b1; addr = 32'h0000_0014;
    step();
    req = 1'b0;
    step(); step();
    checks += 1;
    if (data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL coll_new got=%h exp=deadbeef", data); end
    step();
  endtask

  task automatic test_reset_mid_wait;
    req = 1'b1; addr = 32'h0000_001C;
    step();
    req = 1'b0;
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'hBBBB_BBBB;
    step();
    wr_en = 1'b0;
    checks += 4;
    if (valid !== 1'b0) begin failures++; $display("FAIL rmw_valid got=%b exp=0", valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rmw_busy got=%b exp=0", busy); end
    if (err !== 1'b0) begin failures++; $display("FAIL rmw_err got=%b exp=0", err); end
    if (data !== 32'd0) begin failures++; $display("FAIL rmw_data got=%h exp=0", data); end
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks += 1;
      if (valid !== 1'b0) begin failures++; $display("FAIL rmw_novalid c=%0d got=%b exp=0", c, valid); end
      step();
    end
    req = 1'b1; addr = 32'h0000_001C;
    step();
    req = 1'b0;
    step(); step();
    checks += 1;
    if (data !== 32'hAAAA_0007) begin failures++; $display("FAIL rmw_mem got=%h exp=aaaa0007", data); end
    step();
  endtask

  task automatic test_zero_wait;
    logic [31:0] aseq [3];
    logic [31:0] dseq [3];
    aseq[0] = 32'h0000_0000; dseq[0] = 32'h0000_0013;
    aseq[1] = 32'h0000_0004; dseq[1] = 32'h0010_0093;
    aseq[2] = 32'h0000_0014; dseq[2] = 32'hDEAD_BEEF;
    checks += 2;
    if (valid_z !== 1'b0) begin failures++; $display("FAIL zw_idle_valid got=%b exp=0", valid_z); end
    if (busy_z !== 1'b0) begin failures++; $display("FAIL zw_idle_busy got=%b exp=0", busy_z); end
    req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr0 = aseq[i];
      step();
      checks += 4;
      if (valid_z !== 1'b1) begin failures++; $display("FAIL zw_valid i=%0d got=%b exp=1", i, valid_z); end
      if (busy_z !== 1'b1) begin failures++; $display("FAIL zw_busy i=%0d got=%b exp=1", i, busy_z); end
      if (data_z !== dseq[i]) begin failures++; $display("FAIL zw_data i=%0d got=%h exp=%h", i, data_z, dseq[i]); end
      if (err_z !== 1'b0) begin failures++; $display("FAIL zw_err i=%0d got=%b exp=0", i, err_z); end
    end
    req0 = 1'b0;
    step();
    checks += 2;
    if (valid_z !== 1'b0) begin failures++; $display("FAIL zw_end_valid got=%b exp=0", valid_z); end
    if (busy_z !== 1'b0) begin failures++; $display("FAIL zw_end_busy got=%b exp=0", busy_z); end
  endtask

  initial begin
    test_reset();
    load_program();
    test_basic_fetch();
    test_back_to_back();
    test_faults();
    test_collision();
    test_reset_mid_wait();
    test_zero_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
